// File: rtl/gate_timing_gen.sv
// gate_timing_gen: generates the STV/CPV/OE gate-driver timing for one panel scan.
//
// A scan is line_num lines, each cpv_period clocks long. A free-running pixel
// counter (pc) and a line counter step through the scan. All pulse outputs are
// registered from the next-state counters, so the edge that accepts start
// already shows the line-0/pc-0 levels.
//
// Ports:
//   clk_20mhz, rst_20mhz  - clock, synchronous active-high reset
//   start, abort          - scan request pulse / terminate current scan
//   cfg_*                 - scan configuration, sampled only when start is accepted
//   tg_stv, tg_cpv, tg_oe - registered gate timing pulses
//   busy                  - scan in progress
//   done                  - one-cycle pulse after the last clock of the last line
//   cfg_err               - one-cycle pulse when start is rejected for bad config
//   line_cnt              - current line index
//   frame_cnt             - completed-scan count (wraps)
//
// Build option: define GATE_TG_OE_GEN_EN to build the OE generator; otherwise
// tg_oe is tied low and cfg_oe_start/cfg_oe_width are ignored.
module gate_timing_gen #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LINE_W = 12
) (
    input  logic              clk_20mhz,
    input  logic              rst_20mhz,
    input  logic              start,
    input  logic              abort,
    input  logic [LINE_W-1:0] cfg_line_num,
    input  logic [CNT_W-1:0]  cfg_cpv_period,
    input  logic [CNT_W-1:0]  cfg_cpv_high,
    input  logic [CNT_W-1:0]  cfg_stv_width,
    input  logic [CNT_W-1:0]  cfg_oe_start,
    input  logic [CNT_W-1:0]  cfg_oe_width,
    output logic              tg_stv,
    output logic              tg_cpv,
    output logic              tg_oe,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [LINE_W-1:0] line_cnt,
    output logic [31:0]       frame_cnt
);

    typedef enum logic {StIdle = 1'b0, StScan = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       frame_d;

    logic [LINE_W-1:0] line_num_q;
    logic [CNT_W-1:0]  period_q, cpv_high_q, stv_width_q;

    logic load;
    logic cfg_valid;
    logic done_d, err_d;
    logic stv_d, cpv_d, oe_d;
    logic in_scan_d;

    // Compare thresholds for the next cycle: on the accepting edge the latch
    // is not yet loaded, so use the live config inputs.
    logic [CNT_W-1:0] eff_cpv_high, eff_stv_width;

    assign cfg_valid = (cfg_line_num != '0) && (cfg_cpv_period >= CNT_W'(2)) &&
                       (cfg_cpv_high != '0) && (cfg_cpv_high < cfg_cpv_period);

    assign eff_cpv_high  = load ? cfg_cpv_high  : cpv_high_q;
    assign eff_stv_width = load ? cfg_stv_width : stv_width_q;

    assign busy     = (state_q == StScan);
    assign line_cnt = line_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        line_d  = line_q;
        frame_d = frame_cnt;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    if (cfg_valid) begin
                        load    = 1'b1;
                        state_d = StScan;
                        pc_d    = '0;
                        line_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (abort) begin
                    state_d = StIdle;
                    pc_d    = '0;
                    line_d  = '0;
                end else if (pc_q == period_q - CNT_W'(1)) begin
                    pc_d = '0;
                    if (line_q == line_num_q - LINE_W'(1)) begin
                        state_d = StIdle;
                        line_d  = '0;
                        done_d  = 1'b1;
                        frame_d = frame_cnt + 32'd1;
                    end else begin
                        line_d = line_q + LINE_W'(1);
                    end
                end else begin
                    pc_d = pc_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef GATE_TG_OE_GEN_EN
    logic [CNT_W-1:0] oe_start_q, oe_width_q;
    logic [CNT_W-1:0] eff_oe_start, eff_oe_width;
    logic [CNT_W:0]   oe_end;

    assign eff_oe_start = load ? cfg_oe_start : oe_start_q;
    assign eff_oe_width = load ? cfg_oe_width : oe_width_q;
    // One extra bit so start + width never wraps back into the line
    assign oe_end = {1'b0, eff_oe_start} + {1'b0, eff_oe_width};

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            oe_start_q <= '0;
            oe_width_q <= '0;
        end else if (load) begin
            oe_start_q <= cfg_oe_start;
            oe_width_q <= cfg_oe_width;
        end
    end
`else
    logic unused_oe_cfg;
    assign unused_oe_cfg = ^{cfg_oe_start, cfg_oe_width};
`endif

    // Output next values, derived from next-state counters
    always_comb begin
        in_scan_d = (state_d == StScan);
        cpv_d     = in_scan_d && (pc_d < eff_cpv_high);
        stv_d     = in_scan_d && (line_d == '0) && (pc_d < eff_stv_width);
`ifdef GATE_TG_OE_GEN_EN
        oe_d      = in_scan_d && (pc_d >= eff_oe_start) && ({1'b0, pc_d} < oe_end);
`else
        oe_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            line_q      <= '0;
            frame_cnt   <= '0;
            line_num_q  <= '0;
            period_q    <= '0;
            cpv_high_q  <= '0;
            stv_width_q <= '0;
            tg_stv      <= 1'b0;
            tg_cpv      <= 1'b0;
            tg_oe       <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            line_q    <= line_d;
            frame_cnt <= frame_d;
            if (load) begin
                line_num_q  <= cfg_line_num;
                period_q    <= cfg_cpv_period;
                cpv_high_q  <= cfg_cpv_high;
                stv_width_q <= cfg_stv_width;
            end
            tg_stv  <= stv_d;
            tg_cpv  <= cpv_d;
            tg_oe   <= oe_d;
            done    <= done_d;
            cfg_err <= err_d;
        end
    end

endmodule
